// File: rtl/shift_normalizer_if.sv
// -----------------------------------------------------------------------------
// shift_normalizer_if
// Groups the request/result signals of the shift normalizer.
//   start  : request to normalize din (master -> slave)
//   din    : N-bit unsigned operand (master -> slave)
//   busy   : normalizer is working on an operand (slave -> master)
//   done   : one-cycle pulse, results valid (slave -> master)
//   dout   : top W bits of the normalized operand (slave -> master)
//   shamt  : number of left shifts applied (slave -> master)
//   zero   : captured operand was zero (slave -> master)
// -----------------------------------------------------------------------------
interface shift_normalizer_if #(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int CW = 4
);
  logic          start;
  logic [N-1:0]  din;
  logic          busy;
  logic          done;
  logic [W-1:0]  dout;
  logic [CW-1:0] shamt;
  logic          zero;

  modport master (
    output start, din,
    input  busy, done, dout, shamt, zero
  );

  modport slave (
    input  start, din,
    output busy, done, dout, shamt, zero
  );
endinterface

// File: rtl/shift_normalizer.sv
// -----------------------------------------------------------------------------
// shift_normalizer
// Iterative leading-zero normalizer. An accepted operand is shifted left one
// bit per cycle until its MSB is set; the top W bits and the shift count are
// then latched and announced with a single-cycle done pulse. A zero operand
// skips the shift loop and reports zero=1 directly.
//   clk : sole clock, all state changes on posedge
//   rst : synchronous reset, active-low
//   bus : shift_normalizer_if.slave (start, din in; busy, done, dout,
//         shamt, zero out)
// Parameters: N data width, W output slice width (W <= N),
//             CW shift-count width = ceil(log2(N)).
// -----------------------------------------------------------------------------
module shift_normalizer #(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int CW = 4
) (
  input logic               clk,
  input logic               rst,
  shift_normalizer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Declaration initializers give the reset values at power-up as well.
  state_t        state = IDLE;
  state_t        state_next;
  logic [N-1:0]  sreg    = '0;
  logic [CW-1:0] cnt     = '0;
  logic [W-1:0]  dout_r  = '0;
  logic [CW-1:0] shamt_r = '0;
  logic          zero_r  = 1'b0;

  logic is_busy;
  logic is_done;
  logic load;
  logic load_zero;
  logic step;
  logic latch;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.din == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (sreg[N-1]) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath-control decode of the current state
  always_comb begin
    is_busy   = (state != IDLE);
    is_done   = (state == DONE);
    load      = (state == IDLE) && bus.start && (bus.din != '0);
    load_zero = (state == IDLE) && bus.start && (bus.din == '0);
    step      = (state == SHIFT) && !sreg[N-1];
    latch     = (state == SHIFT) && sreg[N-1];
  end

  // Datapath. A nonzero operand needs at most N-1 shifts before its MSB is
  // set, so cnt never exceeds N-1 and cannot wrap. Result registers keep
  // their previous values until a new result is latched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg    <= '0;
      cnt     <= '0;
      dout_r  <= '0;
      shamt_r <= '0;
      zero_r  <= 1'b0;
    end else begin
      if (load) begin
        sreg <= bus.din;
        cnt  <= '0;
      end else if (step) begin
        sreg <= {sreg[N-2:0], 1'b0};
        cnt  <= cnt + 1'b1;
      end

      if (load_zero) begin
        dout_r  <= '0;
        shamt_r <= '0;
        zero_r  <= 1'b1;
      end else if (latch) begin
        dout_r  <= sreg[N-1 -: W];
        shamt_r <= cnt;
        zero_r  <= 1'b0;
      end
    end
  end

  assign bus.busy  = is_busy;
  assign bus.done  = is_done;
  assign bus.dout  = dout_r;
  assign bus.shamt = shamt_r;
  assign bus.zero  = zero_r;

endmodule

// File: tb/tb_shift_normalizer.sv
// -----------------------------------------------------------------------------
// tb_shift_normalizer
// Directed bench for shift_normalizer (N=16, W=8, CW=4). The driver issues
// requests and pushes the expected result plus the expected done cycle into
// a scoreboard queue; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_shift_normalizer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  shift_normalizer_if #(.N(16), .W(8), .CW(4)) bus ();

  shift_normalizer #(.N(16), .W(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] dout;
    logic [3:0] shamt;
    logic       zero;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int cyc      = 0;
  int n_vec    = 0;
  int n_miss   = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("dout", bus.dout, e.dout);
        check("shamt", bus.shamt, e.shamt);
        check("zero", bus.zero, e.zero);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic wait_idle();
    for (int i = 0; i < 50 && bus.busy !== 1'b0; i++) @(negedge clk);
    check("idle_seen", bus.busy, 32'd0);
  endtask

  // Returns at the negedge of the done cycle (or after the budget expires).
  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got = 1'b1;
    end
    check("done_seen", got, 32'd1);
  endtask

  // Issue a request whose done is expected 'edges' posedges after and
  // including the accepting edge.
  task automatic req(input logic [15:0] d, input logic [7:0] ed,
                     input logic [3:0] es, input logic ez, input int edges);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.din   = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("accept_busy", bus.busy, 32'd1);
    e.dout  = ed;
    e.shamt = es;
    e.zero  = ez;
    e.cyc   = cyc + edges - 1;
    sb.push_back(e);
    wait_done();
  endtask

  task automatic check_all_zero();
    check("rst_busy", bus.busy, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    check("rst_shamt", bus.shamt, 32'd0);
    check("rst_zero", bus.zero, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc;
    exp_t e;
    bus.start = 1'b0;
    bus.din   = '0;

    // Power-up values, before any reset
    @(negedge clk);
    check_all_zero();

    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero();

    // Basic normalizations
    req(16'h8000, 8'h80, 4'd0,  1'b0, 2);
    req(16'h0001, 8'h80, 4'd15, 1'b0, 17);
    req(16'h00F3, 8'hF3, 4'd8,  1'b0, 10);
    req(16'h0000, 8'h00, 4'd0,  1'b1, 1);

    // start held high with a new din while busy: ignored
    wait_idle();
    dc = done_cnt;
    bus.start = 1'b1;
    bus.din   = 16'h0100;
    @(posedge clk);
    #1 bus.din = 16'h8000;
    e.dout  = 8'h80;
    e.shamt = 4'd7;
    e.zero  = 1'b0;
    e.cyc   = cyc + 8;
    sb.push_back(e);
    wait_done();
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("held_done_count", done_cnt, dc + 1);

    // Reset in the middle of a shift sequence aborts it
    wait_idle();
    dc = done_cnt;
    bus.start = 1'b1;
    bus.din   = 16'h0001;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_shift_busy", bus.busy, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero();
    repeat (25) @(negedge clk);
    check("abort_no_done", done_cnt, dc);

    // Back-to-back: second start accepted on the first IDLE edge after DONE
    req(16'h4000, 8'h80, 4'd1, 1'b0, 3);
    @(negedge clk);
    check("b2b_idle", bus.busy, 32'd0);
    req(16'h0003, 8'hC0, 4'd14, 1'b0, 16);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 SHALL have parameter N, default 16, data width of din and of the internal shift register.
REQ-002 SHALL have parameter W, default 8, width of the normalized output slice (W <= N).
REQ-003 SHALL have parameter CW, default 4, shift-count width, equal to ceil(log2(N)).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-low; rst==0 at a posedge resets the block.
REQ-006 SHALL have port start  input  1  request to normalize din; sampled only in IDLE.
REQ-007 SHALL have port din  input  N  unsigned operand; captured on the edge that accepts start.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have port dout  output  W  top W bits of the normalized operand.
REQ-011 SHALL have port shamt  output  CW  number of left shifts applied.
REQ-012 SHALL have port zero  output  1  high when the captured operand was 0.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL, in IDLE with start==1 and din!=0, load din into the internal N-bit register, clear the shift counter, and go to SHIFT.
REQ-015 SHALL, in IDLE with start==1 and din==0, go directly to DONE with zero=1, dout=0, shamt=0.
REQ-016 SHALL, in SHIFT with register MSB==0, shift the register left by one (LSB filled with 0), increment the counter, and stay in SHIFT.
REQ-017 SHALL, in SHIFT with register MSB==1, latch dout=register[N-1:N-W], shamt=counter, zero=0, and go to DONE.
REQ-018 SHALL assert done for exactly the single cycle spent in DONE, then return to IDLE unconditionally.
REQ-019 SHALL give latency for nonzero din with k leading zeros: done high in the cycle after the (k+2)th posedge, counting the start-accepting edge as edge 1.
REQ-020 SHALL give latency for din==0: done high in the cycle after the start-accepting edge.
REQ-021 SHALL bound k at N-1 for nonzero operands; the counter SHALL never wrap.
REQ-022 SHALL ignore start while busy==1, including in DONE; din changes while busy SHALL have no effect.
REQ-023 SHALL hold dout, shamt and zero stable from entry to DONE until the next accepted start updates them.
REQ-024 SHALL accept a new start in IDLE on the edge immediately following the DONE cycle (no dead cycle beyond DONE).
REQ-025 SHALL drive all outputs from registers; no combinational path from start/din to outputs.

Reset
REQ-026 SHALL, on rst==0 at a posedge, force state IDLE and set busy=0, done=0, dout=0, shamt=0, zero=0, and clear the internal register and counter.
REQ-027 SHALL let reset override start and all FSM activity in the same edge.
REQ-028 SHALL, on reset during SHIFT or DONE, abort the operation with no done pulse afterwards.
REQ-029 SHALL reach the same reset values at power-up initialization before the first reset.

Verification
REQ-030 SHALL cover: din=0x8000, start -> done after 2 edges, dout=0x80, shamt=0, zero=0.
REQ-031 SHALL cover: din=0x0001, start -> done after 17 edges, dout=0x80, shamt=15, zero=0.
REQ-032 SHALL cover: din=0x00F3, start -> done after 10 edges, dout=0xF3, shamt=8; din=0x0000 -> done after 1 edge, zero=1, dout=0, shamt=0.
REQ-033 SHALL cover: start with din=0x0100, then start held high with din=0x8000 during SHIFT -> done once, shamt=7, dout=0x80; second request ignored.
REQ-034 SHALL cover: rst=0 for one edge mid-SHIFT -> next cycle busy=0, all outputs 0, no done pulse for that operation.
REQ-035 SHALL cover: back-to-back starts, 0x4000 then 0x0003 on the edge after done -> shamt=1, dout=0x80, then shamt=14, dout=0xC0.
